// File: rtl/example_producer.sv
// rtl/example_producer.sv - F2C test-data producer filling a chunked ring RAM
// Writes {~n, n} words per chunk, pads short chunks with zeros, publishes by advancing wrPtr.
module example_producer #(
   parameter int PTR_BITS = 3,
   parameter int OFF_BITS = 4
) (
   input  logic                sysClk_i,
   input  logic                sysRst_n_i,
   input  logic [31:0]         countInit_i,
   input  logic                start_i,
   output logic                busy_o,
   input  logic [PTR_BITS-1:0] rdPtr_i,
   output logic [PTR_BITS-1:0] wrPtr_o,
   output logic                dtCommit_o,
   output logic                wrEnable_o,
   output logic [7:0]          wrByteMask_o,
   output logic [OFF_BITS-1:0] wrOffset_o,
   output logic [63:0]         wrData_o,
   output logic [63:0]         csData_o,
   output logic                csValid_o,
   input  logic                csReset_i
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_SPACE = 3'd1,
      FILL       = 3'd2,
      PAD        = 3'd3,
      COMMIT     = 3'd4,
      DONE       = 3'd5
   } state_t;

   state_t              state_q;
   logic [31:0]         seq_q;
   logic [31:0]         remaining_q;
   logic [OFF_BITS-1:0] offset_q;
   logic [PTR_BITS-1:0] wrPtr_q;
   logic                busy_q;
   logic                dtCommit_q;
   logic                wrEnable_q;
   logic [63:0]         wrData_q;
   logic [63:0]         csData_q;
   logic                csValid_q;

   logic [63:0]         word_d;
   logic [PTR_BITS-1:0] wrPtr_inc_d;
   logic                ring_full_d;
   logic                last_off_d;

   assign word_d      = {~seq_q, seq_q};
   assign wrPtr_inc_d = wrPtr_q + PTR_BITS'(1);
   // One slot is sacrificed so that equal pointers always mean "ring empty".
   assign ring_full_d = (wrPtr_inc_d == rdPtr_i);
   assign last_off_d  = (offset_q == {OFF_BITS{1'b1}});

   always_ff @(posedge sysClk_i or negedge sysRst_n_i) begin
      if (!sysRst_n_i) begin
         state_q     <= IDLE;
         seq_q       <= '0;
         remaining_q <= '0;
         offset_q    <= '0;
         wrPtr_q     <= '0;
         busy_q      <= 1'b0;
         dtCommit_q  <= 1'b0;
         wrEnable_q  <= 1'b0;
         wrData_q    <= '0;
         csData_q    <= '0;
         csValid_q   <= 1'b0;
      end else begin
         dtCommit_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  remaining_q <= countInit_i;
                  seq_q       <= '0;
                  offset_q    <= '0;
                  csData_q    <= '0;
                  csValid_q   <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= (countInit_i == 32'd0) ? DONE : WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (!ring_full_d) begin
                  state_q     <= FILL;
                  wrEnable_q  <= 1'b1;
                  wrData_q    <= word_d;
                  csData_q    <= csData_q + word_d;
                  seq_q       <= seq_q + 32'd1;
                  remaining_q <= remaining_q - 32'd1;
               end
            end
            FILL, PAD: begin
               if (last_off_d) begin
                  state_q    <= COMMIT;
                  wrEnable_q <= 1'b0;
                  wrData_q   <= '0;
                  offset_q   <= '0;
                  wrPtr_q    <= wrPtr_inc_d;
                  dtCommit_q <= 1'b1;
               end else begin
                  offset_q <= offset_q + OFF_BITS'(1);
                  if (remaining_q != 32'd0) begin
                     state_q     <= FILL;
                     wrData_q    <= word_d;
                     csData_q    <= csData_q + word_d;
                     seq_q       <= seq_q + 32'd1;
                     remaining_q <= remaining_q - 32'd1;
                  end else begin
                     state_q  <= PAD;
                     wrData_q <= '0;
                  end
               end
            end
            COMMIT: begin
               state_q <= (remaining_q == 32'd0) ? DONE : WAIT_SPACE;
            end
            DONE: begin
               csValid_q <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // Checksum clear wins over any update made by the FSM in the same cycle.
         if (csReset_i) begin
            csData_q  <= '0;
            csValid_q <= 1'b0;
         end
      end
   end

   assign busy_o       = busy_q;
   assign wrPtr_o      = wrPtr_q;
   assign dtCommit_o   = dtCommit_q;
   assign wrEnable_o   = wrEnable_q;
   assign wrByteMask_o = {8{wrEnable_q}};
   assign wrOffset_o   = offset_q;
   assign wrData_o     = wrData_q;
   assign csData_o     = csData_q;
   assign csValid_o    = csValid_q;

endmodule

// File: tb/tb_example_producer.sv
// tb/tb_example_producer.sv - scoreboard bench for example_producer
// Chunk-level reference model feeds expected writes, commits and checksums to a negedge monitor.
module tb_example_producer;
   localparam int PB = 3;
   localparam int OB = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   countInit;
   logic          start;
   logic          busy;
   logic [PB-1:0] rdPtr;
   logic [PB-1:0] wrPtr;
   logic          dtCommit;
   logic          wrEnable;
   logic [7:0]    wrByteMask;
   logic [OB-1:0] wrOffset;
   logic [63:0]   wrData;
   logic [63:0]   csData;
   logic          csValid;
   logic          csReset;

   always #5 clk = ~clk;

   example_producer #(.PTR_BITS(PB), .OFF_BITS(OB)) dut (
      .sysClk_i(clk), .sysRst_n_i(rst_n), .countInit_i(countInit), .start_i(start),
      .busy_o(busy), .rdPtr_i(rdPtr), .wrPtr_o(wrPtr), .dtCommit_o(dtCommit),
      .wrEnable_o(wrEnable), .wrByteMask_o(wrByteMask), .wrOffset_o(wrOffset),
      .wrData_o(wrData), .csData_o(csData), .csValid_o(csValid), .csReset_i(csReset)
   );

   typedef struct {
      logic [PB-1:0] ptr;
      logic [OB-1:0] off;
      logic [63:0]   data;
   } wr_t;

   wr_t           exp_wr[$];
   logic [PB-1:0] exp_cm[$];
   logic [63:0]   exp_cs[$];
   logic [PB-1:0] model_wp;
   bit            host_en;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", msg);
   endfunction

   // Whole-run prediction: ceil(cnt/CW) chunks, word n = {~n, n}, zero pad, sum of real words.
   task automatic model_run(input int cnt);
      logic [63:0] sum;
      int nch;
      wr_t w;
      sum = 64'd0;
      nch = (cnt + CW - 1) / CW;
      for (int k = 0; k < nch; k++) begin
         for (int o = 0; o < CW; o++) begin
            int idx;
            idx   = k * CW + o;
            w.ptr = model_wp + PB'(k);
            w.off = OB'(o);
            if (idx < cnt) begin
               w.data = {~32'(idx), 32'(idx)};
               sum    = sum + w.data;
            end else begin
               w.data = 64'd0;
            end
            exp_wr.push_back(w);
         end
         exp_cm.push_back(model_wp + PB'(k + 1));
      end
      model_wp = model_wp + PB'(nch);
      exp_cs.push_back(sum);
   endtask

   always @(negedge clk) begin : monitor
      wr_t           w;
      logic [PB-1:0] cm;
      logic [PB-1:0] unread;
      logic          cs_prev;
      if (!rst_n) begin
         cs_prev = 1'b0;
      end else begin
         if (wrEnable) begin
            if (exp_wr.size() == 0) begin
               fail_now($sformatf("unexpected_write: ptr %0d off %0d data %h, no write expected",
                                  wrPtr, wrOffset, wrData));
            end else begin
               w = exp_wr.pop_front();
               chk("wr_ptr", 64'(wrPtr), 64'(w.ptr));
               chk("wr_off", 64'(wrOffset), 64'(w.off));
               chk("wr_data", wrData, w.data);
            end
            chk("wr_mask", 64'(wrByteMask), 64'hFF);
            unread = wrPtr - rdPtr;
            chk("ring_not_full_on_write", 64'(unread != 3'd7), 64'd1);
         end else begin
            chk("idle_mask", 64'(wrByteMask), 64'd0);
         end
         if (dtCommit) begin
            if (exp_cm.size() == 0) begin
               fail_now($sformatf("unexpected_commit: wrPtr %0d, no commit expected", wrPtr));
            end else begin
               cm = exp_cm.pop_front();
               chk("commit_wrptr", 64'(wrPtr), 64'(cm));
            end
         end
         if (csValid && !cs_prev) begin
            if (exp_cs.size() == 0) begin
               fail_now($sformatf("unexpected_csvalid: csData %h, no run expected", csData));
            end else begin
               chk("checksum", csData, exp_cs.pop_front());
            end
         end
         cs_prev = csValid;
      end
   end

   // Host consumer: randomly frees published chunks.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (host_en && rst_n && rdPtr != wrPtr && $urandom_range(0, 2) == 0)
            rdPtr = rdPtr + PB'(1);
      end
   end

   function automatic logic any_output();
      return |{busy, wrPtr, dtCommit, wrEnable, wrByteMask, wrOffset, wrData, csData, csValid};
   endfunction

   task automatic start_run(input int cnt, input bit stray, input bit cs_clr);
      model_run(cnt);
      @(posedge clk); #1;
      countInit = 32'(cnt);
      start     = 1'b1;
      csReset   = cs_clr;
      @(posedge clk); #1;
      start     = 1'b0;
      csReset   = 1'b0;
      if (stray && cnt > 0) begin
         repeat (4) @(posedge clk);
         #1;
         countInit = $urandom;
         start     = 1'b1;
         @(posedge clk); #1;
         start     = 1'b0;
      end
   endtask

   task automatic wait_done(input int bound, input string tag);
      int k;
      k = 0;
      while (csValid !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (csValid !== 1'b1) begin
         fail_now($sformatf("%s_timeout: csValid %b after %0d cycles, expected 1", tag, csValid, k));
      end else begin
         chk({tag, "_busy"}, 64'(busy), 64'd0);
         chk({tag, "_pending_writes"}, 64'(exp_wr.size()), 64'd0);
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      exp_wr.delete();
      exp_cm.delete();
      exp_cs.delete();
      model_wp = '0;
      rdPtr    = '0;
      start    = 1'b0;
      csReset  = 1'b0;
      #1;
      chk("reset_outputs_zero", 64'(any_output()), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin : stim
      int k;
      int n_we;
      int n_busy;
      rst_n = 1'b0; countInit = '0; start = 1'b0; rdPtr = '0; csReset = 1'b0;
      host_en = 1'b0; model_wp = '0;
      #1;
      chk("por_outputs_zero", 64'(any_output()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_we = 0;
      repeat (10) begin
         @(negedge clk);
         n_we += int'(wrEnable);
      end
      chk("idle_no_write", 64'(n_we), 64'd0);

      start_run(32, 1'b0, 1'b0);
      wait_done(200, "run32");
      chk("run32_csdata", csData, 64'hFFFFFDF0_000001F0);
      chk("run32_wrptr", 64'(wrPtr), 64'd2);

      // Ring-full stall with the host never consuming.
      do_reset();
      start_run(128, 1'b0, 1'b0);
      k = 0;
      while (wrPtr != 3'd7 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("fill_to_full_wrptr", 64'(wrPtr), 64'd7);
      n_we = 0;
      n_busy = 0;
      repeat (40) begin
         @(negedge clk);
         n_we   += int'(wrEnable);
         n_busy += int'(busy);
      end
      chk("stall_no_write", 64'(n_we), 64'd0);
      chk("stall_busy", 64'(n_busy), 64'd40);
      rdPtr = 3'd1;
      wait_done(100, "run128");
      chk("run128_wrap_wrptr", 64'(wrPtr), 64'd0);

      rdPtr = model_wp;
      start_run(20, 1'b0, 1'b0);
      wait_done(200, "run20");

      start_run(0, 1'b0, 1'b0);
      wait_done(3, "run0");
      chk("run0_csdata", csData, 64'd0);

      host_en = 1'b1;
      for (int r = 0; r < 12; r++) begin
         start_run($urandom_range(0, 100), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_done(5000, "rand");
      end
      host_en = 1'b0;

      @(posedge clk); #1;
      csReset = 1'b1;
      @(posedge clk); #1;
      csReset = 1'b0;
      @(negedge clk);
      chk("csreset_csdata", csData, 64'd0);
      chk("csreset_csvalid", 64'(csValid), 64'd0);

      // Reset in the middle of chunk 1: partial chunk must be abandoned.
      do_reset();
      start_run(40, 1'b0, 1'b0);
      k = 0;
      while (!(wrPtr == 3'd1 && wrOffset == 4'd5 && wrEnable) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("midrun_reached_chunk1", 64'(wrPtr == 3'd1 && wrOffset == 4'd5 && wrEnable), 64'd1);
      do_reset();
      n_we = 0;
      repeat (10) begin
         @(negedge clk);
         n_we += int'(wrEnable) + int'(dtCommit);
      end
      chk("after_reset_quiet", 64'(n_we), 64'd0);
      chk("after_reset_wrptr", 64'(wrPtr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
